hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Parametrised successor to the single-cycle load-use detector. Sits beside the ID stage of the
//  5-stage MIPS pipeline. Stalls IF/ID for a configurable number of load-use cycles and for the
//  multiply/divide unit while it is busy. Squashes the ID instruction on a branch taken in EX.
//  Counts stall cycles for performance monitoring.
// PARAMETERS
//  INSTR_W     32  instruction width
//  REG_W       5   register-specifier width
//  LOAD_STALL  1   bubbles per load-use hazard (>=1; >1 for multi-cycle data memory)
//  MD_LAT      4   cycles the mult/div unit stays busy after issue (>=1)
//  PERF_W      16  width of the stall-cycle counter
// PORTS
//  clk            in   1        clock, rising edge
//  reset          in   1        asynchronous, active-low
//  ID_Instr       in   INSTR_W  instruction currently in ID
//  EX_rt          in   REG_W    destination rt of the instruction in EX
//  EX_MemRead     in   1        EX instruction is a load
//  EX_MdStart     in   1        EX instruction is mult/multu/div/divu
//  EX_BranchTaken in   1        branch/jump resolved taken in EX
//  PC_Write       out  1        PC write enable
//  ID_Write       out  1        IF/ID register write enable
//  nop_mux        out  1        1 = inject bubble into ID/EX
//  IF_Flush       out  1        1 = clear IF/ID (wrong-path fetch)
//  stall_count    out  PERF_W   saturating count of stall cycles
// BEHAVIOUR
//  - While reset is low: FSM=IDLE, ld_cnt=0, md_cnt=0, stall_count=0.
//    Outputs are PC_Write=1, ID_Write=1, nop_mux=0, IF_Flush=0.
//  - Operand use is decoded from ID_Instr:
//      uses_rs: all except j, jal, lui, and sll/srl/sra.
//      uses_rt: R-type, beq, bne, sw.
//  - load_haz (combinational) = EX_MemRead && EX_rt!=0 &&
//      ((uses_rs && EX_rt==rs) || (uses_rt && EX_rt==rt)).
//    Register $0 never hazards.
//  - md_haz = ID is mfhi/mflo/mult/multu/div/divu && (md_cnt!=0 || EX_MdStart).
//  - FSM IDLE / LSTALL:
//      IDLE: if load_haz && !EX_BranchTaken and LOAD_STALL>1, go to LSTALL with ld_cnt=LOAD_STALL-1.
//      LSTALL: stall asserted every cycle. ld_cnt decrements. Go to IDLE in the cycle ld_cnt==1.
//    Total bubbles per hazard = LOAD_STALL exactly. With LOAD_STALL=1, LSTALL is never entered.
//  - md_cnt: loads MD_LAT when EX_MdStart, otherwise decrements toward 0.
//    It is not cleared by a branch flush, because the EX instruction is older and on the correct path.
//  - stall = (IDLE && load_haz) || LSTALL || md_haz.
//      On stall: PC_Write=0, ID_Write=0, nop_mux=1.
//  - Branch flush has priority over stall. When EX_BranchTaken=1:
//      IF_Flush=1, nop_mux=1, PC_Write=1, ID_Write=1.
//      FSM goes to IDLE and ld_cnt is cleared.
//  - stall_count increments on every cycle with stall && !EX_BranchTaken.
//    It saturates at all-ones and does not wrap.
//  - All outputs except stall_count are combinational from state plus inputs, giving 0-cycle
//    detection latency. State updates on the clk rising edge.
//  - Reset asserted mid-stall: aborts immediately to IDLE. Outputs return to their reset values
//    in the same cycle.
//  - Load and md hazards at the same time: a single stall. Both counters advance independently,
//    so the stall lasts max(remaining) cycles.
// STRUCTURE
//  - hazard_pkg holds:
//      opcode/funct constants (J, JAL, LUI, BEQ, BNE, SW, MFHI, MFLO, MULT..DIVU, SLL, SRL, SRA);
//      the FSM state encoding (IDLE, LSTALL);
//      the field-slice localparams for rs/rt/opcode/funct.
//  - Sub-module hazard_decode (combinational) takes ID_Instr and produces uses_rs, uses_rt,
//    is_md, rs, rt.
//  - The top level contains the FSM, ld_cnt, md_cnt, perf counter and output muxing.
// TESTING
//  1. LOAD_STALL=1. EX lw rt=8, EX_MemRead=1. ID add $9,$8,$10.
//     -> exactly 1 cycle with PC_Write=0, ID_Write=0, nop_mux=1. stall_count=1.
//  2. LOAD_STALL=3, same pair -> 3 consecutive stall cycles, then IDLE. stall_count=3.
//     Repeat with ID using $0 and EX_rt=0 -> no stall.
//  3. MD_LAT=4. Pulse EX_MdStart, then ID mflo $2 -> stall until md_cnt reaches 0
//     (4 cycles after issue). Then ID_Write=1.
//  4. LOAD_STALL=3. Raise EX_BranchTaken during the 2nd stall cycle
//     -> same cycle IF_Flush=1, PC_Write=1, nop_mux=1. Next cycle FSM=IDLE.
//     stall_count is not incremented for the flush cycle.
//  5. Drop reset low in the middle of an LSTALL and md_busy period
//     -> outputs at reset values immediately, counters 0. After release, no residual stall.
//  6. PERF_W=4. Drive 20 hazard cycles -> stall_count holds at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the ID-stage hazard controller: MIPS opcode/funct values,
// instruction field positions and the load-stall FSM states.
package hazard_pkg;

   localparam int OP_HI = 31;
   localparam int OP_LO = 26;
   localparam int RS_HI = 25;
   localparam int RS_LO = 21;
   localparam int RT_HI = 20;
   localparam int RT_LO = 16;
   localparam int FN_HI = 5;
   localparam int FN_LO = 0;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   typedef enum logic {
      IDLE   = 1'b0,
      LSTALL = 1'b1
   } hz_state_e;

   function automatic logic is_md_funct(input logic [5:0] fn);
      return (fn == FN_MFHI) || (fn == FN_MFLO) || (fn == FN_MULT) ||
             (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
   endfunction

endpackage

// File: rtl/hazard_decode.sv
// Operand-use decode of the instruction sitting in ID: which source registers
// it reads and whether it touches the HI/LO multiply/divide unit.
module hazard_decode
   import hazard_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int REG_W   = 5
) (
   input  logic [INSTR_W-1:0] instr,
   output logic               uses_rs,
   output logic               uses_rt,
   output logic               is_md,
   output logic [REG_W-1:0]   rs,
   output logic [REG_W-1:0]   rt
);

   logic [5:0] op;
   logic [5:0] fn;
   logic       is_shamt;
   logic       unused_bits;

   assign op = instr[OP_HI:OP_LO];
   assign fn = instr[FN_HI:FN_LO];
   assign rs = REG_W'(instr[RS_HI:RS_LO]);
   assign rt = REG_W'(instr[RT_HI:RT_LO]);

   // immediate / rd / shamt fields carry no source-register information
   assign unused_bits = ^instr[15:6];

   assign is_shamt = (op == OP_RTYPE) &&
                     ((fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA));

   assign uses_rs = !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI) || is_shamt);
   assign uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
   assign is_md   = (op == OP_RTYPE) && is_md_funct(fn);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: multi-cycle load-use stall, mult/div busy stall,
// branch-taken flush of IF/ID and a saturating stall-cycle counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int INSTR_W    = 32,
   parameter int REG_W      = 5,
   parameter int LOAD_STALL = 1,
   parameter int MD_LAT     = 4,
   parameter int PERF_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] ID_Instr,
   input  logic [REG_W-1:0]   EX_rt,
   input  logic               EX_MemRead,
   input  logic               EX_MdStart,
   input  logic               EX_BranchTaken,
   output logic               PC_Write,
   output logic               ID_Write,
   output logic               nop_mux,
   output logic               IF_Flush,
   output logic [PERF_W-1:0]  stall_count
);

   localparam int LDW = $clog2(LOAD_STALL + 1);
   localparam int MDW = $clog2(MD_LAT + 1);

   logic             uses_rs, uses_rt, is_md;
   logic [REG_W-1:0] id_rs, id_rt;
   logic             load_haz, md_haz, stall;

   hz_state_e        state_q, state_d;
   logic [LDW-1:0]   ld_cnt_q, ld_cnt_d;
   logic [MDW-1:0]   md_cnt_q, md_cnt_d;
   logic [PERF_W-1:0] stall_count_q, stall_count_d;

   hazard_decode #(.INSTR_W(INSTR_W), .REG_W(REG_W)) u_decode (
      .instr   (ID_Instr),
      .uses_rs (uses_rs),
      .uses_rt (uses_rt),
      .is_md   (is_md),
      .rs      (id_rs),
      .rt      (id_rt)
   );

   assign load_haz = EX_MemRead && (EX_rt != '0) &&
                     ((uses_rs && (EX_rt == id_rs)) || (uses_rt && (EX_rt == id_rt)));
   assign md_haz   = is_md && ((md_cnt_q != '0) || EX_MdStart);
   assign stall    = ((state_q == IDLE) && load_haz) || (state_q == LSTALL) || md_haz;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         ld_cnt_q      <= '0;
         md_cnt_q      <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         ld_cnt_q      <= ld_cnt_d;
         md_cnt_q      <= md_cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

   // The first bubble is taken from IDLE, so LSTALL only covers the remaining LOAD_STALL-1.
   always_comb begin
      state_d  = state_q;
      ld_cnt_d = ld_cnt_q;
      if (EX_BranchTaken) begin
         state_d  = IDLE;
         ld_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_haz && (LOAD_STALL > 1)) begin
                  state_d  = LSTALL;
                  ld_cnt_d = LDW'(LOAD_STALL - 1);
               end
            end
            LSTALL: begin
               ld_cnt_d = ld_cnt_q - 1'b1;
               if (ld_cnt_q == LDW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // The mult/div in EX is older than the branch, so a flush leaves md_cnt alone.
   always_comb begin
      md_cnt_d      = md_cnt_q;
      stall_count_d = stall_count_q;
      if (EX_MdStart)
         md_cnt_d = MDW'(MD_LAT);
      else if (md_cnt_q != '0)
         md_cnt_d = md_cnt_q - 1'b1;
      if (stall && !EX_BranchTaken && (stall_count_q != '1))
         stall_count_d = stall_count_q + 1'b1;
   end

   always_comb begin
      PC_Write = 1'b1;
      ID_Write = 1'b1;
      nop_mux  = 1'b0;
      IF_Flush = 1'b0;
      if (!reset) begin
         PC_Write = 1'b1;
      end else if (EX_BranchTaken) begin
         IF_Flush = 1'b1;
         nop_mux  = 1'b1;
      end else if (stall) begin
         PC_Write = 1'b0;
         ID_Write = 1'b0;
         nop_mux  = 1'b1;
      end
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (LOAD_STALL=1, LOAD_STALL=3,
// PERF_W=4) share stimulus; expected responses are queued and checked at negedge.
module tb_hazard_ctrl;

   localparam logic [31:0] ADD8 = 32'h010A4820;  // add $9,$8,$10
   localparam logic [31:0] ADD0 = 32'h00004820;  // add $9,$0,$0
   localparam logic [31:0] LUI8 = 32'h3C081234;  // lui $8,0x1234
   localparam logic [31:0] SW8  = 32'hAC680000;  // sw  $8,0($3)
   localparam logic [31:0] MFLO = 32'h00001012;  // mflo $2
   localparam logic [31:0] NOP  = 32'h00000000;

   localparam logic [3:0] RUN = 4'b1100;  // {PC_Write, ID_Write, nop_mux, IF_Flush}
   localparam logic [3:0] STL = 4'b0010;
   localparam logic [3:0] FLS = 4'b1111;

   typedef struct {
      int         cyc;
      int         inst;
      logic [3:0] o;
      int         cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ID_Instr;
   logic [4:0]  EX_rt;
   logic        EX_MemRead, EX_MdStart, EX_BranchTaken;

   logic        pcw1, idw1, nop1, fl1;
   logic        pcw3, idw3, nop3, fl3;
   logic        pcw4, idw4, nop4, fl4;
   logic [15:0] cnt1, cnt3;
   logic [3:0]  cnt4;

   exp_t sb[$];
   exp_t e;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc_no = -1;
   logic [3:0] got_o;
   int   got_c;

   always #5 clk = ~clk;

   hazard_ctrl #(.LOAD_STALL(1), .MD_LAT(4), .PERF_W(16)) u_ls1 (
      .clk(clk), .reset(reset), .ID_Instr(ID_Instr), .EX_rt(EX_rt),
      .EX_MemRead(EX_MemRead), .EX_MdStart(EX_MdStart), .EX_BranchTaken(EX_BranchTaken),
      .PC_Write(pcw1), .ID_Write(idw1), .nop_mux(nop1), .IF_Flush(fl1), .stall_count(cnt1));

   hazard_ctrl #(.LOAD_STALL(3), .MD_LAT(4), .PERF_W(16)) u_ls3 (
      .clk(clk), .reset(reset), .ID_Instr(ID_Instr), .EX_rt(EX_rt),
      .EX_MemRead(EX_MemRead), .EX_MdStart(EX_MdStart), .EX_BranchTaken(EX_BranchTaken),
      .PC_Write(pcw3), .ID_Write(idw3), .nop_mux(nop3), .IF_Flush(fl3), .stall_count(cnt3));

   hazard_ctrl #(.LOAD_STALL(1), .MD_LAT(4), .PERF_W(4)) u_p4 (
      .clk(clk), .reset(reset), .ID_Instr(ID_Instr), .EX_rt(EX_rt),
      .EX_MemRead(EX_MemRead), .EX_MdStart(EX_MdStart), .EX_BranchTaken(EX_BranchTaken),
      .PC_Write(pcw4), .ID_Write(idw4), .nop_mux(nop4), .IF_Flush(fl4), .stall_count(cnt4));

   // inst 0 = u_ls1, 1 = u_ls3, 2 = u_p4
   always @(negedge clk) begin
      while (sb.size() != 0) begin
         e = sb.pop_front();
         case (e.inst)
            0:       begin got_o = {pcw1, idw1, nop1, fl1}; got_c = int'(cnt1); end
            1:       begin got_o = {pcw3, idw3, nop3, fl3}; got_c = int'(cnt3); end
            default: begin got_o = {pcw4, idw4, nop4, fl4}; got_c = int'(cnt4); end
         endcase
         n_chk++;
         if (got_o !== e.o || got_c != e.cnt) begin
            n_fail++;
            $display("FAIL cyc%0d inst%0d: outputs %b count %0d, expected %b count %0d",
                     e.cyc, e.inst, got_o, got_c, e.o, e.cnt);
         end
      end
   end

   task automatic apply(input logic rst, input logic [31:0] instr, input logic [4:0] rt,
                        input logic mr, input logic md, input logic br);
      @(posedge clk);
      #1;
      reset          = rst;
      ID_Instr       = instr;
      EX_rt          = rt;
      EX_MemRead     = mr;
      EX_MdStart     = md;
      EX_BranchTaken = br;
      cyc_no++;
   endtask

   task automatic chk(input int inst, input logic [3:0] o, input int cnt);
      exp_t x;
      x.cyc  = cyc_no;
      x.inst = inst;
      x.o    = o;
      x.cnt  = cnt;
      sb.push_back(x);
   endtask

   initial begin
      reset = 1'b0; ID_Instr = NOP; EX_rt = '0;
      EX_MemRead = 1'b0; EX_MdStart = 1'b0; EX_BranchTaken = 1'b0;

      // reset held with a live load-use hazard on the inputs
      apply(0, ADD8, 8, 1, 0, 0); chk(0, RUN, 0); chk(1, RUN, 0); chk(2, RUN, 0);

      // load-use: one bubble vs three bubbles
      apply(1, ADD8, 8, 1, 0, 0); chk(0, STL, 0); chk(1, STL, 0);
      apply(1, ADD8, 0, 0, 0, 0); chk(0, RUN, 1); chk(1, STL, 1);
      apply(1, ADD8, 0, 0, 0, 0); chk(0, RUN, 1); chk(1, STL, 2);
      apply(1, ADD8, 0, 0, 0, 0); chk(0, RUN, 1); chk(1, RUN, 3);

      // $0 never hazards; lui does not read rt; sw hazards through rt
      apply(1, ADD0, 0, 1, 0, 0); chk(0, RUN, 1); chk(1, RUN, 3);
      apply(1, LUI8, 8, 1, 0, 0); chk(1, RUN, 3);
      apply(1, SW8,  8, 1, 0, 0); chk(0, STL, 1); chk(1, STL, 3);
      apply(1, SW8,  0, 0, 0, 0); chk(0, RUN, 2); chk(1, STL, 4);
      apply(1, SW8,  0, 0, 0, 0); chk(1, STL, 5);
      apply(1, SW8,  0, 0, 0, 0); chk(1, RUN, 6);

      // branch taken in the second stall cycle
      apply(1, ADD8, 8, 1, 0, 0); chk(1, STL, 6); chk(0, STL, 2);
      apply(1, ADD8, 0, 0, 0, 1); chk(1, FLS, 7); chk(0, FLS, 3);
      apply(1, ADD8, 0, 0, 0, 0); chk(1, RUN, 7); chk(0, RUN, 3);
      apply(1, ADD8, 0, 0, 0, 0); chk(1, RUN, 7);

      // mult/div busy
      apply(1, NOP,  0, 0, 1, 0); chk(1, RUN, 7);
      apply(1, MFLO, 0, 0, 0, 0); chk(1, STL, 7);
      apply(1, MFLO, 0, 0, 0, 0); chk(1, STL, 8);
      apply(1, MFLO, 0, 0, 0, 0); chk(1, STL, 9);
      apply(1, MFLO, 0, 0, 0, 0); chk(1, STL, 10);
      apply(1, MFLO, 0, 0, 0, 0); chk(1, RUN, 11); chk(0, RUN, 7);
      apply(1, MFLO, 0, 0, 1, 0); chk(1, STL, 11); chk(0, STL, 7);
      apply(1, ADD8, 0, 0, 0, 0); chk(1, RUN, 12); chk(0, RUN, 8);

      // reset dropped during LSTALL with md busy
      apply(1, ADD8, 8, 1, 0, 0); chk(1, STL, 12); chk(0, STL, 8);
      apply(1, MFLO, 0, 0, 0, 0); chk(1, STL, 13); chk(0, STL, 9);
      apply(0, MFLO, 0, 0, 0, 0); chk(0, RUN, 0); chk(1, RUN, 0); chk(2, RUN, 0);
      apply(1, MFLO, 0, 0, 0, 0); chk(0, RUN, 0); chk(1, RUN, 0); chk(2, RUN, 0);
      apply(1, MFLO, 0, 0, 0, 0); chk(1, RUN, 0);

      // 20 consecutive hazard cycles: 4-bit counter saturates at 15
      for (int i = 0; i < 20; i++) begin
         apply(1, ADD8, 8, 1, 0, 0);
         chk(2, STL, (i > 15) ? 15 : i);
         chk(0, STL, i);
      end
      apply(1, ADD8, 0, 0, 0, 0); chk(2, RUN, 15); chk(0, RUN, 20);
      apply(1, ADD8, 0, 0, 0, 0); chk(2, RUN, 15);

      @(negedge clk);
      #1;
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
